awgn_urng: RTL and testbench
============================

Name: awgn_urng

Overview:
- Dual combined-Tausworthe (taus88) uniform random number generator. It is the first stage of the Box-Muller AWGN datapath.
- Each enabled cycle it produces a 48-bit uniform u0 and a 16-bit uniform u1.
- u0 feeds the log/sqrt stage.
- u1 feeds the 16-bit sincos stage input directly.
- Two independent taus88 generators, A and B, each hold three 32-bit state registers. Seeds are runtime-loadable.

Parameters:
- SEED_A0, 32'h12345678, reset value of A.s0 (must be > 1)
- SEED_A1, 32'h9ABCDEF0, reset value of A.s1 (must be > 7)
- SEED_A2, 32'h0F1E2D3C, reset value of A.s2 (must be > 15)
- SEED_B0, 32'hCAFEBABE, reset value of B.s0 (must be > 1)
- SEED_B1, 32'hDEADBEEF, reset value of B.s1 (must be > 7)
- SEED_B2, 32'h13579BDF, reset value of B.s2 (must be > 15)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- en  input  1  advance both generators by one step
- seed_load  input  1  write seed_data into the state register selected by seed_idx
- seed_idx  input  3  0..2 = A.s0..A.s2, 3..5 = B.s0..B.s2, 6..7 = ignored
- seed_data  input  32  seed value
- u0  output  48  {A_out[31:0], B_out[31:16]}, to log/sqrt stage
- u1  output  16  B_out[15:0], to sincos stage input
- valid  output  1  u0/u1 hold a fresh sample this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - State registers are set to their SEED_* parameters.
  - u0=0, u1=0, valid=0.
- Step function, per generator, all arithmetic 32-bit unsigned with overflow bits discarded:
  - b=((s0<<13)^s0)>>19; s0'=((s0&32'hFFFFFFFE)<<12)^b
  - b=((s1<<2)^s1)>>25; s1'=((s1&32'hFFFFFFF8)<<4)^b
  - b=((s2<<3)^s2)>>11; s2'=((s2&32'hFFFFFFF0)<<17)^b
  - out = s0'^s1'^s2' (XOR of the *updated* state).
- Priority on each posedge: seed_load > en > idle.
- seed_load=1:
  - The selected register gets seed_data after sanitisation.
  - Sanitisation: if seed_data <= the minimum for that slot (1 for s0, 7 for s1, 15 for s2), the register instead gets its SEED_* parameter.
  - seed_idx 6/7: no state change.
  - Generators do not advance even if en=1. valid<=0 and u0/u1 hold.
- en=1, seed_load=0:
  - Both generators step.
  - u0 <= {A_out, B_out[31:16]}, u1 <= B_out[15:0], valid <= 1.
  - Latency: sample appears on outputs 1 cycle after the en edge.
  - Throughput: one sample per cycle under continuous en.
- en=0, seed_load=0: state holds; u0/u1 hold their last value; valid <= 0.
- Loading several slots takes consecutive seed_load cycles. Each slot takes effect on the next step.
- State never reaches the all-zero fixed point, because sanitisation and the parameter constraints prevent it.
- Reset mid-stream: state reverts to the parameters immediately; previously loaded seeds are lost.
- Determinism: an identical seed set plus an identical en pattern must give a bit-identical sequence.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: assert rst=0 with en=1 toggling -> u0=0, u1=0, valid=0 throughout. Release, en=1 for 1 cycle -> valid=1 for exactly one cycle; the sample matches the C taus88 model with default seeds.
- Known seeds: load A={2,8,16} and B={2,8,16} via idx 0..5, then en=1 for 2 cycles:
  - 1st sample: A_out=B_out=32'h00202080, so u0=48'h002020800020, u1=16'h2080.
  - 2nd sample: A_out=B_out=32'h02002C80, so u0=48'h02002C800200, u1=16'h2C80.
- Sanitisation: load A.s0=1, A.s1=7, A.s2=0 (all illegal) plus default B, run 8 samples -> sequence is identical to the post-reset default sequence.
- Priority: seed_load=1 and en=1 in the same cycle -> no step, valid=0 next cycle, outputs unchanged. The next en-only cycle yields the step computed from the newly loaded seed.
- Stall/hold: en pattern 1,0,0,1 -> valid 1,0,0,1 one cycle later; u0/u1 are held during the en=0 cycles. The 2nd sample equals the model's 2nd step (no skipped or duplicated steps).
- Long run and mid-stream reset: 10,000 continuous samples compared against the C model; u1 fed to the sincos stage is bit-exact. Pull rst low at sample 5000 -> outputs clear and the sequence restarts from sample 1.

Source files
------------

// File: rtl/awgn_urng_if.sv
// Request/sample bundle between the uniform RNG and its seed controller / Box-Muller consumer.
interface awgn_urng_if;
  logic        en;
  logic        seed_load;
  logic [2:0]  seed_idx;
  logic [31:0] seed_data;
  logic [47:0] u0;
  logic [15:0] u1;
  logic        valid;

  modport master (output en, seed_load, seed_idx, seed_data,
                  input  u0, u1, valid);
  modport slave  (input  en, seed_load, seed_idx, seed_data,
                  output u0, u1, valid);
endinterface

// File: rtl/awgn_urng.sv
// Dual taus88 uniform generator feeding the Box-Muller AWGN stages.
// u0 = {A_out, B_out[31:16]} for log/sqrt, u1 = B_out[15:0] for sincos.
module awgn_urng #(
  parameter logic [31:0] SEED_A0 = 32'h12345678,
  parameter logic [31:0] SEED_A1 = 32'h9ABCDEF0,
  parameter logic [31:0] SEED_A2 = 32'h0F1E2D3C,
  parameter logic [31:0] SEED_B0 = 32'hCAFEBABE,
  parameter logic [31:0] SEED_B1 = 32'hDEADBEEF,
  parameter logic [31:0] SEED_B2 = 32'h13579BDF
) (
  input  logic        clk,
  input  logic        rst,
  awgn_urng_if.slave  bus
);

  localparam logic [31:0] SEED_DFLT [6] = '{SEED_A0, SEED_A1, SEED_A2,
                                            SEED_B0, SEED_B1, SEED_B2};

  logic [31:0] st_q   [6];
  logic [31:0] st_nxt [6];
  logic [31:0] a_out, b_out;
  logic [31:0] seed_min, seed_dflt_sel, seed_san;
  logic [47:0] u0_q;
  logic [15:0] u1_q;
  logic        valid_q;

  function automatic logic [31:0] step_s0(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 13) ^ s) >> 19;
    return ((s & 32'hFFFFFFFE) << 12) ^ b;
  endfunction

  function automatic logic [31:0] step_s1(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 2) ^ s) >> 25;
    return ((s & 32'hFFFFFFF8) << 4) ^ b;
  endfunction

  function automatic logic [31:0] step_s2(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 3) ^ s) >> 11;
    return ((s & 32'hFFFFFFF0) << 17) ^ b;
  endfunction

  always_comb begin
    st_nxt[0] = step_s0(st_q[0]);
    st_nxt[1] = step_s1(st_q[1]);
    st_nxt[2] = step_s2(st_q[2]);
    st_nxt[3] = step_s0(st_q[3]);
    st_nxt[4] = step_s1(st_q[4]);
    st_nxt[5] = step_s2(st_q[5]);
    a_out     = st_nxt[0] ^ st_nxt[1] ^ st_nxt[2];
    b_out     = st_nxt[3] ^ st_nxt[4] ^ st_nxt[5];
  end

  // Seeds at or below the slot minimum would collapse taus88 toward zero; fall back to the default.
  always_comb begin
    seed_min      = 32'd15;
    seed_dflt_sel = 32'd0;
    case (bus.seed_idx)
      3'd0: begin seed_min = 32'd1;  seed_dflt_sel = SEED_A0; end
      3'd1: begin seed_min = 32'd7;  seed_dflt_sel = SEED_A1; end
      3'd2: begin seed_min = 32'd15; seed_dflt_sel = SEED_A2; end
      3'd3: begin seed_min = 32'd1;  seed_dflt_sel = SEED_B0; end
      3'd4: begin seed_min = 32'd7;  seed_dflt_sel = SEED_B1; end
      3'd5: begin seed_min = 32'd15; seed_dflt_sel = SEED_B2; end
      default: ;
    endcase
    seed_san = (bus.seed_data <= seed_min) ? seed_dflt_sel : bus.seed_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) st_q[i] <= SEED_DFLT[i];
      u0_q    <= '0;
      u1_q    <= '0;
      valid_q <= 1'b0;
    end else if (bus.seed_load) begin
      for (int i = 0; i < 6; i++)
        if (bus.seed_idx == 3'(i)) st_q[i] <= seed_san;
      valid_q <= 1'b0;
    end else if (bus.en) begin
      for (int i = 0; i < 6; i++) st_q[i] <= st_nxt[i];
      u0_q    <= {a_out, b_out[31:16]};
      u1_q    <= b_out[15:0];
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.u0    = u0_q;
  assign bus.u1    = u1_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_awgn_urng.sv
// Bench for awgn_urng: table-driven taus88 reference model plus directed and random stimulus.
module tb_awgn_urng;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  awgn_urng_if bus();
  awgn_urng dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: slots 0..2 generator A, 3..5 generator B
  logic [31:0] ms [6];
  logic [47:0] m_u0;
  logic [15:0] m_u1;
  logic        m_v;
  logic [47:0] def_u0 [8];
  logic [15:0] def_u1 [8];

  // taus88 component table: shift q, shift k, shift r, mask, minimum legal seed
  int          tq [3] = '{13, 2, 3};
  int          tk [3] = '{19, 25, 11};
  int          tr [3] = '{12, 4, 17};
  logic [31:0] tm [3] = '{32'hFFFFFFFE, 32'hFFFFFFF8, 32'hFFFFFFF0};
  logic [31:0] tmin [3] = '{32'd1, 32'd7, 32'd15};
  logic [31:0] dflt [6] = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C,
                            32'hCAFEBABE, 32'hDEADBEEF, 32'h13579BDF};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] taus(input logic [31:0] s, input int c);
    logic [31:0] b;
    b = ((s << tq[c]) ^ s) >> tk[c];
    return ((s & tm[c]) << tr[c]) ^ b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) ms[i] = dflt[i];
    m_u0 = '0; m_u1 = '0; m_v = 1'b0;
  endtask

  task automatic model_clock(input logic en_i, input logic ld_i,
                             input logic [2:0] idx_i, input logic [31:0] d_i);
    logic [31:0] outg [2];
    int slot;
    if (ld_i) begin
      slot = int'(idx_i);
      if (slot < 6)
        ms[slot] = (d_i <= tmin[slot % 3]) ? dflt[slot] : d_i;
      m_v = 1'b0;
    end else if (en_i) begin
      for (int g = 0; g < 2; g++) begin
        outg[g] = 32'd0;
        for (int c = 0; c < 3; c++) begin
          ms[3*g+c] = taus(ms[3*g+c], c);
          outg[g] ^= ms[3*g+c];
        end
      end
      m_u0 = {outg[0], outg[1][31:16]};
      m_u1 = outg[1][15:0];
      m_v  = 1'b1;
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic cyc(input logic en_i, input logic ld_i,
                     input logic [2:0] idx_i, input logic [31:0] d_i);
    bus.en = en_i; bus.seed_load = ld_i; bus.seed_idx = idx_i; bus.seed_data = d_i;
    @(posedge clk);
    #1;
    model_clock(en_i, ld_i, idx_i, d_i);
    check("valid", 64'(bus.valid), 64'(m_v));
    check("u0", 64'(bus.u0), 64'(m_u0));
    check("u1", 64'(bus.u1), 64'(m_u1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_u0", 64'(bus.u0), 64'd0);
    check("rst_u1", 64'(bus.u1), 64'd0);
    check("rst_valid", 64'(bus.valid), 64'd0);
    rst = 1'b1;
    #1;
    model_reset();
  endtask

  initial begin
    int k;
    bus.en = 1'b0; bus.seed_load = 1'b0; bus.seed_idx = '0; bus.seed_data = '0;
    model_reset();

    // outputs stay clear under reset even with en toggling
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.en = i[0];
      @(posedge clk);
      #1;
      check("inrst_u0", 64'(bus.u0), 64'd0);
      check("inrst_u1", 64'(bus.u1), 64'd0);
      check("inrst_valid", 64'(bus.valid), 64'd0);
    end
    rst = 1'b1;
    #1;
    model_reset();
    cyc(1'b1, 1'b0, 3'd0, 32'd0);
    cyc(1'b0, 1'b0, 3'd0, 32'd0);
    cyc(1'b0, 1'b0, 3'd0, 32'd0);

    // record the post-reset default sequence
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 32'd0);
      def_u0[i] = m_u0;
      def_u1[i] = m_u1;
    end

    // known minimal seeds
    for (int i = 0; i < 6; i++) begin
      logic [31:0] sd;
      sd = (i % 3 == 0) ? 32'd2 : (i % 3 == 1) ? 32'd8 : 32'd16;
      cyc(1'b0, 1'b1, 3'(i), sd);
    end
    cyc(1'b1, 1'b0, 3'd0, 32'd0);
    check("known1_u0", 64'(bus.u0), 64'h002020800020);
    check("known1_u1", 64'(bus.u1), 64'h2080);
    cyc(1'b1, 1'b0, 3'd0, 32'd0);
    check("known2_u0", 64'(bus.u0), 64'h02002C800200);
    check("known2_u1", 64'(bus.u1), 64'h2C80);

    // illegal A seeds fall back to defaults, B reloaded with defaults
    cyc(1'b0, 1'b1, 3'd0, 32'd1);
    cyc(1'b0, 1'b1, 3'd1, 32'd7);
    cyc(1'b0, 1'b1, 3'd2, 32'd0);
    cyc(1'b0, 1'b1, 3'd3, dflt[3]);
    cyc(1'b0, 1'b1, 3'd4, dflt[4]);
    cyc(1'b0, 1'b1, 3'd5, dflt[5]);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 32'd0);
      check("san_u0", 64'(bus.u0), 64'(def_u0[i]));
      check("san_u1", 64'(bus.u1), 64'(def_u1[i]));
    end

    // seed_load wins over en; next en step uses the new seed
    cyc(1'b1, 1'b1, 3'd0, 32'h5555AAAA);
    check("prio_valid", 64'(bus.valid), 64'd0);
    check("prio_hold_u0", 64'(bus.u0), 64'(def_u0[7]));
    cyc(1'b1, 1'b0, 3'd0, 32'd0);

    // stall pattern
    cyc(1'b1, 1'b0, 3'd0, 32'd0);
    cyc(1'b0, 1'b0, 3'd0, 32'd0);
    cyc(1'b0, 1'b0, 3'd0, 32'd0);
    cyc(1'b1, 1'b0, 3'd0, 32'd0);

    // random mix of steps, stalls and seed writes (incl. idx 6/7, tiny seeds)
    for (int i = 0; i < 2000; i++) begin
      logic        r_en, r_ld;
      logic [2:0]  r_idx;
      logic [31:0] r_d;
      r_en  = ($urandom_range(3) != 0);
      r_ld  = ($urandom_range(9) == 0);
      r_idx = 3'($urandom_range(7));
      r_d   = ($urandom_range(3) == 0) ? 32'($urandom_range(20)) : $urandom;
      cyc(r_en, r_ld, r_idx, r_d);
    end

    // long continuous run with mid-stream reset
    do_reset();
    k = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        do_reset();
        k = 0;
      end
      cyc(1'b1, 1'b0, 3'd0, 32'd0);
      if (k < 8) begin
        check("restart_u0", 64'(bus.u0), 64'(def_u0[k]));
        check("restart_u1", 64'(bus.u1), 64'(def_u1[k]));
      end
      k++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
